// File: rtl/hazard_unit_pkg.sv
// Shared processor encodings: sequencer states, PC select and forwarding selects.
// Latency: none (constants only); backpressure: none.
package hazard_unit_pkg;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LDSTALL    = 2'd1;
    localparam logic [1:0] ST_HALT_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALTED     = 2'd3;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_JMP = 2'd1;
    localparam logic [1:0] PC_RET = 2'd2;
    localparam logic [1:0] PC_BR  = 2'd3;

    localparam logic [1:0] FWD_REGF = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

    typedef logic [1:0] fwd_sel_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-status inputs and stall/flush/forward controls of the hazard unit.
// master = pipeline/controller side, slave = hazard unit.
interface hazard_unit_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [REG_AW-1:0] idRs1;
    logic [REG_AW-1:0] idRs2;
    logic              idUse1;
    logic              idUse2;
    logic              idHalt;
    logic [REG_AW-1:0] exRd;
    logic              exRegWr;
    logic              exLdm;
    logic [1:0]        exPcSel;
    logic [REG_AW-1:0] memRd;
    logic              memRegWr;
    logic [REG_AW-1:0] wbRd;
    logic              wbRegWr;

    logic              pcWriteEn;
    logic              ifIdWriteEn;
    logic              ifIdFlush;
    logic              idExFlush;
    logic              hazard;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;
    logic              done;
    logic [CNT_W-1:0]  stallCnt;

    modport master (
        output start, idRs1, idRs2, idUse1, idUse2, idHalt,
               exRd, exRegWr, exLdm, exPcSel, memRd, memRegWr, wbRd, wbRegWr,
        input  pcWriteEn, ifIdWriteEn, ifIdFlush, idExFlush, hazard,
               fwdA, fwdB, done, stallCnt
    );

    modport slave (
        input  start, idRs1, idRs2, idUse1, idUse2, idHalt,
               exRd, exRegWr, exLdm, exPcSel, memRd, memRegWr, wbRd, wbRegWr,
        output pcWriteEn, ifIdWriteEn, ifIdFlush, idExFlush, hazard,
               fwdA, fwdB, done, stallCnt
    );

endinterface

// File: rtl/hazard_unit_fwd_unit.sv
// EX operand source select: MEM result beats WB result, else register file.
// Latency: combinational; backpressure: none.
module fwd_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] exRs,
    input  logic [REG_AW-1:0] memRd,
    input  logic              memRegWr,
    input  logic [REG_AW-1:0] wbRd,
    input  logic              wbRegWr,
    output fwd_sel_t          fwd
);

    always_comb begin
        fwd = FWD_REGF;
        if (memRegWr && (memRd == exRs)) begin
            fwd = FWD_MEM;
        end else if (wbRegWr && (wbRd == exRs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// 5-stage pipeline sequencer: load-use/branch hazards, halt drain, forwarding, stall counter.
// Latency: Mealy controls in the same cycle; backpressure: stalls are generated here, none accepted.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_AW     = 3,
    parameter int LOAD_STALL = 1,
    parameter int DRAIN      = 3,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave bus
);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [CNT_W-1:0]  stallCnt;
    logic [REG_AW-1:0] exRs1;
    logic [REG_AW-1:0] exRs2;
    logic              branch;
    logic              loadUse;
    logic              pcWriteEn;
    logic              ifIdWriteEn;
    logic              ifIdFlush;
    logic              idExFlush;
    logic              hazard;
    logic              done;
    fwd_sel_t          fwdA;
    fwd_sel_t          fwdB;

    assign branch  = (bus.exPcSel != PC_SEQ);
    assign loadUse = bus.exLdm & bus.exRegWr &
                     ((bus.idUse1 & (bus.idRs1 == bus.exRd)) |
                      (bus.idUse2 & (bus.idRs2 == bus.exRd)));

    always_comb begin
        pcWriteEn   = 1'b1;
        ifIdWriteEn = 1'b1;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        hazard      = 1'b0;
        done        = 1'b0;
        case (state)
            ST_RUN: begin
                if (branch) begin
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                    hazard    = 1'b1;
                end else if (loadUse) begin
                    pcWriteEn   = 1'b0;
                    ifIdWriteEn = 1'b0;
                    idExFlush   = 1'b1;
                    hazard      = 1'b1;
                end else if (bus.idHalt) begin
                    // the halt itself moves on to EX; only younger fetches die
                    pcWriteEn = 1'b0;
                    ifIdFlush = 1'b1;
                end
            end
            ST_LDSTALL: begin
                pcWriteEn   = 1'b0;
                ifIdWriteEn = 1'b0;
                idExFlush   = 1'b1;
                hazard      = 1'b1;
            end
            ST_HALT_DRAIN: begin
                pcWriteEn   = 1'b0;
                ifIdWriteEn = 1'b0;
                ifIdFlush   = 1'b1;
            end
            default: begin
                pcWriteEn   = 1'b0;
                ifIdWriteEn = 1'b0;
                ifIdFlush   = 1'b1;
                idExFlush   = 1'b1;
                hazard      = 1'b1;
                done        = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HALTED;
            cnt      <= 3'd0;
            stallCnt <= '0;
            exRs1    <= '0;
            exRs2    <= '0;
        end else begin
            // shadow of the ID/EX source fields; a bubble leaves the old values in place
            if (!idExFlush) begin
                exRs1 <= bus.idRs1;
                exRs2 <= bus.idRs2;
            end
            if (!pcWriteEn && ((state == ST_RUN) || (state == ST_LDSTALL)) && !(&stallCnt)) begin
                stallCnt <= stallCnt + 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (branch) begin
                        state <= ST_RUN;
                    end else if (loadUse) begin
                        if (LOAD_STALL > 1) begin
                            state <= ST_LDSTALL;
                            cnt   <= 3'(LOAD_STALL - 1);
                        end
                    end else if (bus.idHalt) begin
                        state <= ST_HALT_DRAIN;
                        cnt   <= 3'(DRAIN);
                    end
                end
                ST_LDSTALL: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd1) state <= ST_RUN;
                end
                ST_HALT_DRAIN: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd1) state <= ST_HALTED;
                end
                default: begin
                    if (bus.start) state <= ST_RUN;
                end
            endcase
        end
    end

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .exRs     (exRs1),
        .memRd    (bus.memRd),
        .memRegWr (bus.memRegWr),
        .wbRd     (bus.wbRd),
        .wbRegWr  (bus.wbRegWr),
        .fwd      (fwdA)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .exRs     (exRs2),
        .memRd    (bus.memRd),
        .memRegWr (bus.memRegWr),
        .wbRd     (bus.wbRd),
        .wbRegWr  (bus.wbRegWr),
        .fwd      (fwdB)
    );

    assign bus.pcWriteEn   = pcWriteEn;
    assign bus.ifIdWriteEn = ifIdWriteEn;
    assign bus.ifIdFlush   = ifIdFlush;
    assign bus.idExFlush   = idExFlush;
    assign bus.hazard      = hazard;
    assign bus.done        = done;
    assign bus.stallCnt    = stallCnt;
    assign bus.fwdA        = (state == ST_HALTED) ? FWD_REGF : fwdA;
    assign bus.fwdB        = (state == ST_HALTED) ? FWD_REGF : fwdB;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed literal checks plus randomized traffic against a cycle model.
// Latency: n/a; backpressure: n/a.
module tb_hazard_unit;

    localparam int REG_AW     = 3;
    localparam int LOAD_STALL = 2;
    localparam int DRAIN      = 3;
    localparam int CNT_W      = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nErrors = 0;

    hazard_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_unit #(
        .REG_AW(REG_AW), .LOAD_STALL(LOAD_STALL), .DRAIN(DRAIN), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Pipeline condition as remaining-cycle counts rather than a state register.
    bit        mValid   = 0;
    bit        mHalted  = 0;
    int        mStall   = 0;
    int        mDrain   = 0;
    int        mStallCnt = 0;
    int        mSrc1    = 0;
    int        mSrc2    = 0;

    function automatic logic [1:0] fwdExp(input int src);
        if (mHalted) return 2'd0;
        if (bus.memRegWr && (int'(bus.memRd) == src)) return 2'd1;
        if (bus.wbRegWr && (int'(bus.wbRd) == src)) return 2'd2;
        return 2'd0;
    endfunction

    always @(negedge clk) begin
        // {pcWriteEn, ifIdWriteEn, ifIdFlush, idExFlush, hazard, done}
        logic [5:0] e;
        bit br;
        bit lu;
        br = (bus.exPcSel != 2'd0);
        lu = bus.exLdm && bus.exRegWr &&
             ((bus.idUse1 && (bus.idRs1 == bus.exRd)) || (bus.idUse2 && (bus.idRs2 == bus.exRd)));
        if (mHalted)          e = 6'b001111;
        else if (mDrain > 0)  e = 6'b001000;
        else if (mStall > 0)  e = 6'b000110;
        else if (br)          e = 6'b111110;
        else if (lu)          e = 6'b000110;
        else if (bus.idHalt)  e = 6'b011000;
        else                  e = 6'b110000;

        if (mValid) begin
            chk("model ctrl {pc,ifwe,iffl,idfl,hz,done}",
                {26'd0, bus.pcWriteEn, bus.ifIdWriteEn, bus.ifIdFlush, bus.idExFlush, bus.hazard, bus.done},
                {26'd0, e});
            chk("model fwdA", {30'd0, bus.fwdA}, {30'd0, fwdExp(mSrc1)});
            chk("model fwdB", {30'd0, bus.fwdB}, {30'd0, fwdExp(mSrc2)});
            chk("model stallCnt", {16'd0, bus.stallCnt}, mStallCnt);
        end

        if (rst) begin
            mValid = 1; mHalted = 1; mStall = 0; mDrain = 0;
            mStallCnt = 0; mSrc1 = 0; mSrc2 = 0;
        end else begin
            if (!e[2]) begin
                mSrc1 = int'(bus.idRs1);
                mSrc2 = int'(bus.idRs2);
            end
            if (!e[5] && !mHalted && (mDrain == 0) && (mStallCnt < 65535)) mStallCnt++;
            if (mHalted) begin
                if (bus.start) mHalted = 0;
            end else if (mDrain > 0) begin
                mDrain--;
                if (mDrain == 0) mHalted = 1;
            end else if (mStall > 0) begin
                mStall--;
            end else if (br) begin
                mStall = 0;
            end else if (lu) begin
                mStall = LOAD_STALL - 1;
            end else if (bus.idHalt) begin
                mDrain = DRAIN;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.start = 0; bus.idRs1 = '0; bus.idRs2 = '0; bus.idUse1 = 0; bus.idUse2 = 0;
        bus.idHalt = 0; bus.exRd = '0; bus.exRegWr = 0; bus.exLdm = 0; bus.exPcSel = 2'd0;
        bus.memRd = '0; bus.memRegWr = 0; bus.wbRd = '0; bus.wbRegWr = 0;
    endtask

    task automatic setLoadUse();
        bus.exLdm = 1; bus.exRegWr = 1; bus.exRd = 3'd3; bus.idRs1 = 3'd3; bus.idUse1 = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        #1;
        chk("reset done", {31'd0, bus.done}, 32'd1);
        chk("reset pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd0);
        chk("reset stallCnt", {16'd0, bus.stallCnt}, 32'd0);
        chk("reset hazard", {31'd0, bus.hazard}, 32'd1);

        bus.start = 1;
        cyc();
        bus.start = 0;
        #1;
        chk("start pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd1);

        // load-use: two stall cycles with LOAD_STALL = 2
        setLoadUse();
        #1;
        chk("lu c1 pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd0);
        chk("lu c1 idExFlush", {31'd0, bus.idExFlush}, 32'd1);
        cyc(); idle(); #1;
        chk("lu c2 pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd0);
        chk("lu c2 idExFlush", {31'd0, bus.idExFlush}, 32'd1);
        cyc(); #1;
        chk("lu end pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd1);
        chk("lu stallCnt", {16'd0, bus.stallCnt}, 32'd2);

        // branch beats load-use
        setLoadUse();
        bus.exPcSel = 2'd3;
        #1;
        chk("br ifIdFlush", {31'd0, bus.ifIdFlush}, 32'd1);
        chk("br idExFlush", {31'd0, bus.idExFlush}, 32'd1);
        chk("br pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd1);
        cyc(); idle(); #1;
        chk("br no stall", {31'd0, bus.pcWriteEn}, 32'd1);
        chk("br stallCnt", {16'd0, bus.stallCnt}, 32'd2);

        // forwarding priority on EX source 1 = 5
        bus.idRs1 = 3'd5;
        cyc();
        bus.memRd = 3'd5; bus.memRegWr = 1; bus.wbRd = 3'd5; bus.wbRegWr = 1;
        #1;
        chk("fwdA mem", {30'd0, bus.fwdA}, 32'd1);
        chk("fwdB none", {30'd0, bus.fwdB}, 32'd0);
        bus.memRegWr = 0;
        #1;
        chk("fwdA wb", {30'd0, bus.fwdA}, 32'd2);

        // halt drain: done four cycles after the halt cycle
        cyc(); idle();
        bus.idHalt = 1;
        #1;
        chk("halt pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd0);
        chk("halt ifIdFlush", {31'd0, bus.ifIdFlush}, 32'd1);
        chk("halt hazard", {31'd0, bus.hazard}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); idle(); #1;
            chk("drain done", {31'd0, bus.done}, 32'd0);
            chk("drain pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd0);
        end
        cyc(); #1;
        chk("halted done", {31'd0, bus.done}, 32'd1);
        chk("halt stallCnt", {16'd0, bus.stallCnt}, 32'd3);
        bus.start = 1;
        cyc();
        bus.start = 0;
        #1;
        chk("restart pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd1);

        // reset while the load stall is in its last cycle
        setLoadUse();
        cyc(); idle();
        rst = 1;
        #1;
        chk("ldstall pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd0);
        cyc();
        rst = 0;
        #1;
        chk("midrst done", {31'd0, bus.done}, 32'd1);
        chk("midrst hazard", {31'd0, bus.hazard}, 32'd1);
        chk("midrst pcWriteEn", {31'd0, bus.pcWriteEn}, 32'd0);
        chk("midrst stallCnt", {16'd0, bus.stallCnt}, 32'd0);
        chk("midrst fwdA", {30'd0, bus.fwdA}, 32'd0);

        // randomized traffic, small register range to provoke matches
        for (int n = 0; n < 3000; n++) begin
            cyc();
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.idRs1    = 3'($urandom_range(0, 3));
            bus.idRs2    = 3'($urandom_range(0, 3));
            bus.idUse1   = 1'($urandom);
            bus.idUse2   = 1'($urandom);
            bus.idHalt   = ($urandom_range(0, 15) == 0);
            bus.exRd     = 3'($urandom_range(0, 3));
            bus.exRegWr  = 1'($urandom);
            bus.exLdm    = ($urandom_range(0, 2) == 0);
            bus.exPcSel  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus.memRd    = 3'($urandom_range(0, 3));
            bus.memRegWr = 1'($urandom);
            bus.wbRd     = 3'($urandom_range(0, 3));
            bus.wbRegWr  = 1'($urandom);
            rst          = ($urandom_range(0, 199) == 0);
        end
        cyc();
        rst = 0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not end within the time budget");
        $fatal(1, "timeout");
    end

endmodule
